systolic_array_nxn: RTL and testbench
=====================================

Name: systolic_array_nxn

Overview:
- Parametrised N×N output-stationary systolic matrix-multiply engine; successor to the fixed 2×2 array.
- Latches full A (N×N) and B (N×N) operand tiles on a start handshake and generates the diagonal skew internally, replacing external per-cycle select lines.
- Runs the wavefront, then presents C = A·B (or A·Bᵀ) with optional ReLU and a done pulse.
- Supports accumulate-across-tiles mode for K > N tiling; sits between the operand memory and the writeback unit.

Parameters:
- N, 4, array dimension (rows = cols = inner K per tile), ≥2
- WIDTH, 8, signed operand width
- ACC_W, 2*WIDTH+$clog2(N)+4, signed accumulator/output width; holds up to 16 accumulated tiles without overflow

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- accumulate  in  1  sampled with start; 1 = keep accumulators, 0 = clear
- transpose  in  1  sampled with start; 1 = use Bᵀ
- activation  in  1  sampled with start; 1 = apply ReLU to outputs
- a_mat  in  N*N*WIDTH  A row-major, element [i][k] at index i*N+k
- b_mat  in  N*N*WIDTH  B row-major, element [k][j] at index k*N+j
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse; c_mat valid from this cycle
- c_mat  out  N*N*ACC_W  C row-major, registered, holds until next done

Behaviour:
- Reset: state IDLE; busy=0, done=0, c_mat=0, accumulators=0, skew pipes=0.
- States: IDLE → FEED (start & !busy) → DONE (t == 3N-3) → IDLE (always, next cycle).
- Acceptance edge: latch a_mat, b_mat, transpose, activation; t←0; if accumulate=0, clear all accumulators.
- FEED, t = 0..3N-3:
  - row i edge input = A[i][t-i] if 0≤t-i<N, else 0
  - col j edge input = B'[t-j][j] if 0≤t-j<N, else 0, where B' = Bᵀ when transpose=1
  - PE(i,j) accumulates A[i][k]·B'[k][j] at the edge ending cycle t = k+i+j.
  - a passes right and b passes down through one register per PE.
- DONE cycle: done=1, busy=0; c_mat registers the accumulator values, ReLU'd per element if activation=1 (negative → 0).
- done is observed 3N-2 clock edges after the acceptance edge (N=2: 4; N=4: 10).
- Arithmetic: signed WIDTH×WIDTH → 2*WIDTH product, sign-extended to ACC_W; two's-complement wrap on overflow (no saturation).
- Accumulators keep their values after DONE, so a subsequent start with accumulate=1 continues the sum.
- start while busy: ignored, with no effect on latched operands. start during the DONE cycle: ignored (busy=0 but state≠IDLE; acceptance requires IDLE).
- Operand inputs may change freely after acceptance.
- rst mid-FEED: immediate return to IDLE, all state zeroed, no done pulse.
- Edge-input zeros outside the skew window guarantee no stale products.

Decomposition:
- Package tpu_pkg:
  - state enum (IDLE, FEED, DONE)
  - function acc_width(WIDTH, N)
  - shared ReLU function on ACC_W signed values
- Sub-module systolic_pe:
  - parametrised WIDTH/ACC_W
  - ports clk, rst, clear, a_in, b_in, a_out, b_out, acc_out
  - instantiated N×N in a generate loop
- Skew counter, FSM and output register live in the top module.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], transpose=0 → done 4 edges after acceptance; C=[[19,22],[43,50]].
- N=2, same A, B, transpose=1 → C=[[17,23],[39,53]].
- N=2, A=[[-1,0],[0,-1]], B=[[3,-2],[4,5]], activation=1 → C=[[0,2],[0,0]]; with activation=0 → C=[[-3,2],[-4,-5]].
- N=4, A=B=identity, then start again with accumulate=1 and A=B=identity → first done C=I; second done C=2·I.
- N=4, A=B all -128 → every C element = 4·16384 = 65536 (fits ACC_W=22); second start with accumulate=0 clears to the same value.
- N=4, start asserted during FEED and DONE → ignored; rst asserted at t=5 → busy=0, c_mat=0, no done pulse; a new start after reset completes normally.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the systolic matrix-multiply engine.
//   state_e    : control FSM states (IDLE, FEED, DONE)
//   acc_width  : default accumulator width for a given operand width and N
//   relu       : ReLU on a sign-extended accumulator value (ACC_MAX bits)
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest accumulator the shared ReLU helper handles; callers sign-extend
  // their ACC_W value up to this width and truncate the result back.
  localparam int ACC_MAX = 64;

  // Full-precision product plus growth for N terms, plus 4 bits of headroom
  // so up to 16 accumulated tiles cannot overflow.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n) + 4;
  endfunction

  function automatic logic signed [ACC_MAX-1:0] relu(input logic signed [ACC_MAX-1:0] x);
    return x[ACC_MAX-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary processing element.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : zero the accumulator at this edge (takes priority)
//   a_in / b_in    : operands arriving from the left / from above
//   a_out / b_out  : operands registered one stage, passed right / down
//   acc_out        : value the accumulator takes at the coming edge
module systolic_pe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] a_out,
  output logic signed [WIDTH-1:0] b_out,
  output logic signed [ACC_W-1:0] acc_out
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]   a_q, b_q;

  assign prod = a_in * b_in;

  // Sign-extend the product; wrap-around on overflow is intended.
  always_comb begin
    acc_d = clear ? '0 : acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  // Exposing the next value lets the output register capture the final sum
  // on the same edge that the last product lands in the corner PE.
  assign acc_out = acc_d;

endmodule

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: N x N output-stationary systolic matrix multiplier.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only in IDLE
//   accumulate   : with start, 1 keeps accumulators, 0 clears them
//   transpose    : with start, 1 multiplies by B transposed
//   activation   : with start, 1 applies ReLU to the outputs
//   a_mat, b_mat : operand tiles, row-major, element [r][c] at r*N+c
//   busy         : high while the wavefront runs
//   done         : one-cycle pulse, c_mat valid from this cycle
//   c_mat        : registered result, row-major, held until next done
module systolic_array_nxn
  import tpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int ACC_W = acc_width(WIDTH, N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 accumulate,
  input  logic                 transpose,
  input  logic                 activation,
  input  logic [N*N*WIDTH-1:0] a_mat,
  input  logic [N*N*WIDTH-1:0] b_mat,
  output logic                 busy,
  output logic                 done,
  output logic [N*N*ACC_W-1:0] c_mat
);

  localparam int LAST  = 3 * N - 3;
  localparam int T_W   = $clog2(3 * N - 2);
  localparam int IDX_W = $clog2(N);

  state_e         state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic           accept;
  logic           activation_q;

  // b_q holds B' (already transposed if requested) so the skew logic is uniform.
  logic signed [WIDTH-1:0] a_q [N][N];
  logic signed [WIDTH-1:0] b_q [N][N];

  logic signed [WIDTH-1:0] row_edge [N];
  logic signed [WIDTH-1:0] col_edge [N];
  logic signed [WIDTH-1:0] a_bus [N][N+1];
  logic signed [WIDTH-1:0] b_bus [N+1][N];
  logic signed [ACC_W-1:0] acc_bus [N][N];
  logic signed [ACC_W-1:0] c_q [N][N];
  logic signed [ACC_W-1:0] c_d [N][N];

  assign accept = start && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: if (t_q == T_W'(LAST)) state_d = DONE;
            else                   t_d     = t_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      t_q          <= '0;
      activation_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          a_q[i][k] <= '0;
          b_q[i][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept) begin
        activation_q <= activation;
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < N; k++) begin
            a_q[i][k] <= a_mat[(i*N+k)*WIDTH +: WIDTH];
            b_q[i][k] <= transpose ? b_mat[(k*N+i)*WIDTH +: WIDTH]
                                   : b_mat[(i*N+k)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Diagonal skew: row i starts i cycles late, column j starts j cycles late.
  // Outside the window (and outside FEED) the edges carry zero, so nothing
  // stale is ever multiplied into an accumulator.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_edge[i] = '0;
      col_edge[i] = '0;
    end
    if (state_q == FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(t_q) >= i) && (int'(t_q) - i < N)) begin
          row_edge[i] = a_q[i][IDX_W'(int'(t_q) - i)];
          col_edge[i] = b_q[IDX_W'(int'(t_q) - i)][i];
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_edge
      assign a_bus[gi][0] = row_edge[gi];
      assign b_bus[0][gi] = col_edge[gi];
    end
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        systolic_pe #(
          .WIDTH (WIDTH),
          .ACC_W (ACC_W)
        ) u_pe (
          .clk     (clk),
          .rst     (rst),
          .clear   (accept && !accumulate),
          .a_in    (a_bus[gi][gj]),
          .b_in    (b_bus[gi][gj]),
          .a_out   (a_bus[gi][gj+1]),
          .b_out   (b_bus[gi+1][gj]),
          .acc_out (acc_bus[gi][gj])
        );
        assign c_mat[(gi*N+gj)*ACC_W +: ACC_W] = c_q[gi][gj];
      end
    end
  endgenerate

  always_comb begin
    logic signed [ACC_MAX-1:0] ext;
    logic signed [ACC_MAX-1:0] rel;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ext       = {{(ACC_MAX-ACC_W){acc_bus[i][j][ACC_W-1]}}, acc_bus[i][j]};
        rel       = relu(ext);
        c_d[i][j] = activation_q ? rel[ACC_W-1:0] : acc_bus[i][j];
      end
    end
  end

  // Capture on the edge that ends the last FEED cycle, i.e. entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c_q[i][j] <= '0;
    end else if ((state_q == FEED) && (t_q == T_W'(LAST))) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c_q[i][j] <= c_d[i][j];
    end
  end

  assign busy = (state_q == FEED);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_systolic_array_nxn.sv
module tb_systolic_array_nxn;

  localparam int W    = 8;
  localparam int ACC2 = 2*W + 1 + 4;
  localparam int ACC4 = 2*W + 2 + 4;

  typedef int mat2_t [4];
  typedef int mat4_t [16];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic              start2, accum2, trans2, act2, busy2, done2;
  logic [4*W-1:0]    a2, b2;
  logic [4*ACC2-1:0] c2;

  logic               start4, accum4, trans4, act4, busy4, done4;
  logic [16*W-1:0]    a4, b4;
  logic [16*ACC4-1:0] c4;

  int tests = 0;
  int fails = 0;

  systolic_array_nxn #(.N(2), .WIDTH(W), .ACC_W(ACC2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .accumulate(accum2),
    .transpose(trans2), .activation(act2), .a_mat(a2), .b_mat(b2),
    .busy(busy2), .done(done2), .c_mat(c2)
  );

  systolic_array_nxn #(.N(4), .WIDTH(W), .ACC_W(ACC4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .accumulate(accum4),
    .transpose(trans4), .activation(act4), .a_mat(a4), .b_mat(b4),
    .busy(busy4), .done(done4), .c_mat(c4)
  );

  task automatic check_value(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pack2(input mat2_t m);
    logic [4*W-1:0] p;
    for (int i = 0; i < 4; i++) p[i*W +: W] = W'(m[i]);
    return p;
  endfunction

  function automatic logic [16*W-1:0] pack4(input mat4_t m);
    logic [16*W-1:0] p;
    for (int i = 0; i < 16; i++) p[i*W +: W] = W'(m[i]);
    return p;
  endfunction

  function automatic longint c2_el(input int idx);
    return longint'($signed(c2[idx*ACC2 +: ACC2]));
  endfunction

  function automatic longint c4_el(input int idx);
    return longint'($signed(c4[idx*ACC4 +: ACC4]));
  endfunction

  // Returns just after the acceptance edge; operands are then scrambled.
  task automatic go2(input mat2_t a, input mat2_t b, input logic acc, input logic tr, input logic act);
    @(negedge clk);
    a2 = pack2(a); b2 = pack2(b);
    accum2 = acc; trans2 = tr; act2 = act; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    a2 = $urandom; b2 = $urandom;
    accum2 = 1'($urandom); trans2 = 1'($urandom); act2 = 1'($urandom);
    check_value("busy2_after_accept", longint'(busy2), 1);
  endtask

  task automatic go4(input mat4_t a, input mat4_t b, input logic acc, input logic tr, input logic act);
    @(negedge clk);
    a4 = pack4(a); b4 = pack4(b);
    accum4 = acc; trans4 = tr; act4 = act; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = {4{$urandom}}; b4 = {4{$urandom}};
    accum4 = 1'($urandom); trans4 = 1'($urandom); act4 = 1'($urandom);
    check_value("busy4_after_accept", longint'(busy4), 1);
  endtask

  // Counts edges after acceptance until done; optionally pokes start in the
  // DONE cycle, then checks that done was a single-cycle pulse.
  task automatic wait_done(input int which, input int already, input int exp_edges,
                           input bit poke, input string tag);
    int edges = already;
    bit seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      seen = (which == 2) ? done2 : done4;
    end
    check_value({tag, "_latency"}, seen ? longint'(edges) : -1, exp_edges);
    if (seen) begin
      check_value({tag, "_busy_at_done"}, longint'((which == 2) ? busy2 : busy4), 0);
      if (poke) begin
        start4 = 1'b1; accum4 = 1'b0; a4 = {4{$urandom}}; b4 = {4{$urandom}};
      end
      @(posedge clk); #1;
      start4 = 1'b0;
      check_value({tag, "_done_pulse"}, longint'((which == 2) ? done2 : done4), 0);
      check_value({tag, "_not_accepted"}, longint'((which == 2) ? busy2 : busy4), 0);
    end
  endtask

  task automatic check_c2(input mat2_t e, input string tag);
    for (int i = 0; i < 4; i++)
      check_value($sformatf("%s_c%0d", tag, i), c2_el(i), e[i]);
    $display("[TB] %s: N=2 result compared", tag);
  endtask

  task automatic check_c4(input mat4_t e, input string tag);
    for (int i = 0; i < 16; i++)
      check_value($sformatf("%s_c%0d", tag, i), c4_el(i), e[i]);
    $display("[TB] %s: N=4 result compared", tag);
  endtask

  initial begin
    mat4_t id4, id4x2, m4, neg4, exp_neg;
    int    dseen;

    for (int i = 0; i < 16; i++) begin
      id4[i]     = (i % 5 == 0) ? 1 : 0;
      id4x2[i]   = (i % 5 == 0) ? 2 : 0;
      m4[i]      = i + 1;
      neg4[i]    = -128;
      exp_neg[i] = 65536;
    end

    rst = 1'b1;
    start2 = 0; accum2 = 0; trans2 = 0; act2 = 0; a2 = '0; b2 = '0;
    start4 = 0; accum4 = 0; trans4 = 0; act4 = 0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_busy2", longint'(busy2), 0);
    check_value("rst_done2", longint'(done2), 0);
    check_value("rst_c2_zero", longint'(|c2), 0);
    check_value("rst_busy4", longint'(busy4), 0);
    check_value("rst_done4", longint'(done4), 0);
    check_value("rst_c4_zero", longint'(|c4), 0);
    rst = 1'b0;
    $display("[TB] reset: state compared");

    go2('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1'b0, 1'b0, 1'b0);
    wait_done(2, 0, 4, 1'b0, "mul2");
    check_c2('{19, 22, 43, 50}, "mul2");

    go2('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1'b0, 1'b1, 1'b0);
    wait_done(2, 0, 4, 1'b0, "trans2");
    check_c2('{17, 23, 39, 53}, "trans2");

    go2('{-1, 0, 0, -1}, '{3, -2, 4, 5}, 1'b0, 1'b0, 1'b1);
    wait_done(2, 0, 4, 1'b0, "relu2");
    check_c2('{0, 2, 0, 0}, "relu2");

    go2('{-1, 0, 0, -1}, '{3, -2, 4, 5}, 1'b0, 1'b0, 1'b0);
    wait_done(2, 0, 4, 1'b0, "neg2");
    check_c2('{-3, 2, -4, -5}, "neg2");

    go4(id4, id4, 1'b0, 1'b0, 1'b0);
    wait_done(4, 0, 10, 1'b0, "id4");
    check_c4(id4, "id4");

    go4(id4, id4, 1'b1, 1'b0, 1'b0);
    wait_done(4, 0, 10, 1'b0, "id4_acc");
    check_c4(id4x2, "id4_acc");

    go4(neg4, neg4, 1'b0, 1'b0, 1'b0);
    wait_done(4, 0, 10, 1'b0, "min4");
    check_c4(exp_neg, "min4");

    go4(neg4, neg4, 1'b0, 1'b0, 1'b0);
    wait_done(4, 0, 10, 1'b0, "min4_clr");
    check_c4(exp_neg, "min4_clr");

    // start during FEED (edge 3) and during DONE must both be ignored
    go4(id4, m4, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start4 = 1'b1; accum4 = 1'b0; a4 = pack4(neg4); b4 = pack4(neg4);
    @(posedge clk); #1;
    start4 = 1'b0;
    check_value("ign_busy_mid", longint'(busy4), 1);
    wait_done(4, 3, 10, 1'b1, "ign");
    check_c4(m4, "ign");

    // reset in cycle t=5 aborts the run
    go4(m4, id4, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_value("midrst_busy", longint'(busy4), 0);
    check_value("midrst_done", longint'(done4), 0);
    check_value("midrst_c4_zero", longint'(|c4), 0);
    dseen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done4) dseen++;
    end
    check_value("midrst_no_done", dseen, 0);
    $display("[TB] midrst: abort compared");

    go4(id4, m4, 1'b1, 1'b0, 1'b0);
    wait_done(4, 0, 10, 1'b0, "post_rst");
    check_c4(m4, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
